// File: rtl/prog_loader_mem.sv
// prog_loader_mem: program memory with a load phase (IDLE/LOAD/DONE) followed
// by a terminal RUN phase in which a CPU port may read and write the memory.
// Optional feature macro: PROG_CHECKSUM_EN enables the running load checksum;
// without it the checksum port is tied to zero.
module prog_loader_mem #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 5
) (
  input  logic              clock,
  input  logic              reset,
  input  logic [DATA_W-1:0] prog_data_in,
  input  logic [ADDR_W-1:0] prog_addr,
  input  logic              prog_write_enable,
  input  logic              start_execution,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  input  logic              cpu_we,
  input  logic              cpu_re,
  output logic [DATA_W-1:0] cpu_rdata,
  output logic              cpu_rvalid,
  output logic              load_done,
  output logic              exec_enable,
  output logic [ADDR_W:0]   load_count,
  output logic              prog_error,
  output logic [DATA_W-1:0] checksum
);

  localparam int DEPTH = 2 ** ADDR_W;
  localparam logic [ADDR_W:0] CNT_MAX = (ADDR_W + 1)'(DEPTH);
  localparam logic [ADDR_W:0] CNT_ONE = (ADDR_W + 1)'(1);

  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_DONE, S_RUN} state_t;

  state_t            r_state;
  logic [DATA_W-1:0] r_mem [DEPTH];
  logic [DATA_W-1:0] r_cpu_rdata;
  logic              r_cpu_rvalid;
  logic              r_load_done;
  logic              r_exec_enable;
  logic [ADDR_W:0]   r_load_count;
  logic              r_prog_error;

  logic w_in_run;
  logic w_load_wr;
  logic w_cpu_wr;
  logic w_cpu_rd;

  // Load writes are accepted in every phase except RUN; reset blocks all writes.
  assign w_in_run  = (r_state == S_RUN);
  assign w_load_wr = prog_write_enable && !w_in_run && !reset;
  assign w_cpu_wr  = cpu_we && w_in_run && !reset;
  assign w_cpu_rd  = cpu_re && w_in_run;

  function automatic logic [ADDR_W:0] sat_inc(input logic [ADDR_W:0] c);
    return (c == CNT_MAX) ? c : c + CNT_ONE;
  endfunction

  // Memory array: never reset; load port and CPU port are active in disjoint phases.
  always_ff @(posedge clock) begin
    if (w_load_wr)
      r_mem[prog_addr] <= prog_data_in;
    else if (w_cpu_wr)
      r_mem[cpu_addr] <= cpu_wdata;
  end

  // Registered CPU read; a same-cycle write is seen only by later reads.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_cpu_rvalid <= 1'b0;
      r_cpu_rdata  <= '0;
    end else begin
      r_cpu_rvalid <= w_cpu_rd;
      if (w_cpu_rd)
        r_cpu_rdata <= r_mem[cpu_addr];
    end
  end

  // Phase FSM with registered status outputs.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_state       <= S_IDLE;
      r_load_done   <= 1'b0;
      r_exec_enable <= 1'b0;
      r_load_count  <= '0;
      r_prog_error  <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (prog_write_enable) begin
            r_load_count <= CNT_ONE;
            r_state      <= S_LOAD;
          end
        end
        S_LOAD: begin
          if (prog_write_enable) begin
            r_load_count <= sat_inc(r_load_count);
          end else begin
            r_load_done <= 1'b1;
            r_state     <= S_DONE;
          end
        end
        S_DONE: begin
          // A reload takes precedence over a simultaneous start request.
          if (prog_write_enable) begin
            r_load_count <= CNT_ONE;
            r_load_done  <= 1'b0;
            r_state      <= S_LOAD;
          end else if (start_execution) begin
            r_exec_enable <= 1'b1;
            r_state       <= S_RUN;
          end
        end
        S_RUN: begin
          if (prog_write_enable)
            r_prog_error <= 1'b1;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

`ifdef PROG_CHECKSUM_EN
  logic [DATA_W-1:0] r_checksum;

  // Running sum of accepted load words; a reload from DONE restarts the sum.
  always_ff @(posedge clock) begin
    if (reset)
      r_checksum <= '0;
    else if (w_load_wr) begin
      if (r_state == S_DONE)
        r_checksum <= prog_data_in;
      else
        r_checksum <= r_checksum + prog_data_in;
    end
  end

  assign checksum = r_checksum;
`else
  assign checksum = '0;
`endif

  assign cpu_rdata   = r_cpu_rdata;
  assign cpu_rvalid  = r_cpu_rvalid;
  assign load_done   = r_load_done;
  assign exec_enable = r_exec_enable;
  assign load_count  = r_load_count;
  assign prog_error  = r_prog_error;

endmodule
